// File: rtl/apb3_master_bridge_pkg.sv
// Shared types and elaboration helpers for the APB3 debug master bridge.
package apb3_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb3_mst_state_e;

    // Response payload is sized for the widest debug bus this bridge serves.
    localparam int APB3_RSP_DW = 32;

    typedef struct packed {
        logic [APB3_RSP_DW-1:0] rdata;
        logic                   err;
        logic                   timeout;
    } apb3_rsp_t;

    function automatic int apb3_align_lsbs(input int data_width);
        return (data_width > 8) ? $clog2(data_width / 8) : 0;
    endfunction

    function automatic int apb3_cnt_width(input int cycles);
        return (cycles > 0) ? $clog2(cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/apb3_master_bridge_timeout_counter.sv
// Down-counter that fires when a slave has held pready low for TIMEOUT_CYCLES ACCESS cycles.
module apb3_timeout_counter
    import apb3_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    if (TIMEOUT_CYCLES == 0) begin : g_off
        logic unused_ok;
        assign unused_ok = ^{clk, rst_n, clear_i, enable_i};
        assign expire_o  = 1'b0;
    end else begin : g_on
        localparam int CW = apb3_cnt_width(TIMEOUT_CYCLES);

        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (clear_i) begin
                cnt_d = CW'(TIMEOUT_CYCLES);
            end else if (enable_i && (cnt_q != '0)) begin
                cnt_d = cnt_q - CW'(1);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        // Terminal count: the current stalled cycle is the last one allowed.
        assign expire_o = enable_i && (cnt_q == CW'(1));
    end

endmodule

// File: rtl/apb3_master_bridge.sv
// Valid/ready command stream to APB3 master, with misalignment rejection and pready timeout.
//   state  | meaning
//   IDLE   | cmd_ready high, waiting for a command
//   SETUP  | psel=1 penable=0, single cycle
//   ACCESS | psel=1 penable=1, waiting for pready or timeout
//   RESP   | rsp_valid held with stable payload until rsp_ready
module apb3_master_bridge
    import apb3_pkg::*;
#(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    localparam int ALIGN_LSBS = apb3_align_lsbs(DATA_WIDTH);

    apb3_mst_state_e       state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    apb3_rsp_t             rsp_q, rsp_d;

    logic cmd_accept;
    logic misaligned;
    logic expire;

    assign cmd_accept = cmd_valid && cmd_ready_q;

    if (ALIGN_LSBS > 0) begin : g_align
        assign misaligned = |cmd_addr[ALIGN_LSBS-1:0];
    end else begin : g_noalign
        assign misaligned = 1'b0;
    end

    apb3_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (state_q == SETUP),
        .enable_i ((state_q == ACCESS) && !pready),
        .expire_o (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_q       <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_q       <= rsp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cmd_accept) state_d = misaligned ? RESP : SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (pready || expire) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Flags are registered versions of the next state, so every output is a flop.
    always_comb begin
        cmd_ready_d = (state_d == IDLE);
        psel_d      = (state_d == SETUP) || (state_d == ACCESS);
        penable_d   = (state_d == ACCESS);
        rsp_valid_d = (state_d == RESP);
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_d       = rsp_q;

        if ((state_q == IDLE) && cmd_accept) begin
            pwrite_d = cmd_write;
            paddr_d  = cmd_addr;
            pwdata_d = cmd_wdata;
            if (misaligned) begin
                rsp_d = '{rdata: '0, err: 1'b1, timeout: 1'b0};
            end
        end

        if (state_q == ACCESS) begin
            if (pready) begin
                rsp_d.rdata   = (pwrite_q || pslverr) ? '0 : APB3_RSP_DW'(prdata);
                rsp_d.err     = pslverr;
                rsp_d.timeout = 1'b0;
            end else if (expire) begin
                rsp_d = '{rdata: '0, err: 1'b1, timeout: 1'b1};
            end
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = DATA_WIDTH'(rsp_q.rdata);
    assign rsp_err     = rsp_q.err;
    assign rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_apb3_master_bridge.sv
// Transaction-level bench for apb3_master_bridge: per-command timing windows derived from slave wait counts.
module tb_apb3_master_bridge;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic [AW-1:0] paddr;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata = '0;
    logic          pready = 1'b0;
    logic          pslverr = 1'b0;

    always #5 clk = ~clk;

    apb3_master_bridge #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .paddr      (paddr),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .pwdata     (pwdata),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr)
    );

    // cyc == k during the interval following rising edge k
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Current transaction, expressed as edge indices
    bit            t_valid = 1'b0;
    int            t_acc = 0, t_nacc = 0, t_rsp_start = 0, t_hs = 0, t_hold = 0;
    bit            t_mis = 1'b0, t_write = 1'b0, t_err = 1'b0, t_to = 1'b0;
    logic [AW-1:0] t_addr = '0, h_addr = '0;
    logic [DW-1:0] t_wdata = '0, h_wdata = '0, t_rdata = '0;
    bit            h_write = 1'b0;

    int            sl_wait = 0;
    int            acc_cnt = 0;

    int            cap_psel = 0, cap_pen = 0, first_psel = -1, first_rsp = -1;
    logic [DW-1:0] cap_rdata = '0;
    logic          cap_err = 1'b0, cap_to = 1'b0;

    int            c;
    bit            e_busy, e_psel, e_pen, e_rv;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    bit            e_write;

    // Slave: pready goes high on the (sl_wait+1)-th ACCESS cycle
    initial begin
        forever begin
            @(negedge clk);
            if (psel && penable) begin
                pready = (acc_cnt == sl_wait);
                acc_cnt++;
            end else begin
                pready  = 1'b0;
                acc_cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            c       = cyc;
            e_busy  = t_valid && (c >= t_acc) && (c < t_hs);
            e_psel  = t_valid && !t_mis && (c >= t_acc) && (c <= t_acc + t_nacc);
            e_pen   = t_valid && !t_mis && (c > t_acc) && (c <= t_acc + t_nacc);
            e_rv    = t_valid && (c >= t_rsp_start) && (c < t_hs);
            e_addr  = (t_valid && c >= t_acc) ? t_addr : h_addr;
            e_write = (t_valid && c >= t_acc) ? t_write : h_write;
            e_wdata = (t_valid && c >= t_acc) ? t_wdata : h_wdata;
            chk("cmd_ready", 64'(cmd_ready), 64'(!e_busy));
            chk("psel", 64'(psel), 64'(e_psel));
            chk("penable", 64'(penable), 64'(e_pen));
            chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
            chk("paddr", 64'(paddr), 64'(e_addr));
            chk("pwrite", 64'(pwrite), 64'(e_write));
            chk("pwdata", 64'(pwdata), 64'(e_wdata));
            if (e_rv) begin
                chk("rsp_rdata", 64'(rsp_rdata), 64'(t_rdata));
                chk("rsp_err", 64'(rsp_err), 64'(t_err));
                chk("rsp_timeout", 64'(rsp_timeout), 64'(t_to));
            end
            if (t_valid && c == t_acc) begin
                cap_psel   = 0;
                cap_pen    = 0;
                first_psel = -1;
                first_rsp  = -1;
            end
            if (psel) begin
                cap_psel++;
                if (first_psel < 0) first_psel = c;
            end
            if (penable) cap_pen++;
            if (rsp_valid && first_rsp < 0) begin
                first_rsp = c;
                cap_rdata = rsp_rdata;
                cap_err   = rsp_err;
                cap_to    = rsp_timeout;
            end
        end
    end

    task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input int wt, input logic [DW-1:0] rd, input bit se,
                         input int hold, input bit junk);
        @(negedge clk);
        if (t_valid) begin
            h_addr  = t_addr;
            h_write = t_write;
            h_wdata = t_wdata;
        end
        t_write = wr;
        t_addr  = a;
        t_wdata = wd;
        t_mis   = (a % 4) != 0;
        t_acc   = cyc + 1;
        t_hold  = hold;
        if (t_mis) begin
            t_nacc = 0; t_rsp_start = t_acc; t_err = 1'b1; t_to = 1'b0; t_rdata = '0;
        end else if (wt >= TO) begin
            t_nacc = TO; t_rsp_start = t_acc + 1 + TO; t_err = 1'b1; t_to = 1'b1; t_rdata = '0;
        end else begin
            t_nacc = wt + 1; t_rsp_start = t_acc + 1 + t_nacc; t_err = se; t_to = 1'b0;
            t_rdata = (wr || se) ? '0 : rd;
        end
        t_hs      = t_rsp_start + 1 + hold;
        sl_wait   = wt;
        prdata    = rd;
        pslverr   = se;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = wd;
        rsp_ready = 1'b0;
        t_valid   = 1'b1;
        @(posedge clk);
        #1;
        if (junk) begin
            cmd_write = !wr;
            cmd_addr  = 12'h7FC;
            cmd_wdata = ~wd;
        end else begin
            cmd_valid = 1'b0;
        end
    endtask

    task automatic finish_rsp(input bit junk);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            rsp_ready = (cyc >= t_rsp_start + t_hold);
            if (junk && cyc >= t_hs - 1) cmd_valid = 1'b0;
            if (cyc >= t_hs) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_psel", 64'(psel), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);

        // zero-wait write
        issue(1'b1, 12'h010, 32'hDEADBEEF, 0, 32'h0, 1'b0, 0, 1'b0);
        finish_rsp(1'b0);
        chk("wr_psel_lat", 64'(first_psel - t_acc), 64'd0);
        chk("wr_pen_cycles", 64'(cap_pen), 64'd1);
        chk("wr_rsp_lat", 64'(first_rsp - t_acc), 64'd2);
        chk("wr_rdata", 64'(cap_rdata), 64'd0);
        chk("wr_err", 64'(cap_err), 64'd0);

        // read with 3 wait states (pready on the cycle a timeout would fire), busy cmd_valid, held response
        issue(1'b0, 12'h020, 32'h0000_0055, 3, 32'h12345678, 1'b0, 2, 1'b1);
        finish_rsp(1'b1);
        chk("ws_pen_cycles", 64'(cap_pen), 64'd4);
        chk("ws_rsp_lat", 64'(first_rsp - t_acc), 64'd5);
        chk("ws_rdata", 64'(cap_rdata), 64'h12345678);
        chk("ws_err", 64'(cap_err), 64'd0);

        // misaligned read
        issue(1'b0, 12'h003, 32'h0, 0, 32'hAAAA_AAAA, 1'b0, 0, 1'b0);
        finish_rsp(1'b0);
        chk("mis_psel_cycles", 64'(cap_psel), 64'd0);
        chk("mis_rsp_lat", 64'(first_rsp - t_acc), 64'd0);
        chk("mis_err", 64'(cap_err), 64'd1);
        chk("mis_timeout", 64'(cap_to), 64'd0);

        // hung slave
        issue(1'b0, 12'h080, 32'h0, 1000, 32'hCAFEF00D, 1'b0, 1, 1'b0);
        finish_rsp(1'b0);
        chk("to_pen_cycles", 64'(cap_pen), 64'd4);
        chk("to_err", 64'(cap_err), 64'd1);
        chk("to_timeout", 64'(cap_to), 64'd1);
        chk("to_rdata", 64'(cap_rdata), 64'd0);

        // slave error on read
        issue(1'b0, 12'h040, 32'h0, 1, 32'hFFFFFFFF, 1'b1, 0, 1'b0);
        finish_rsp(1'b0);
        chk("se_err", 64'(cap_err), 64'd1);
        chk("se_timeout", 64'(cap_to), 64'd0);
        chk("se_rdata", 64'(cap_rdata), 64'd0);

        // misaligned write, then a plain read
        issue(1'b1, 12'h7FE, 32'h0BAD_0BAD, 0, 32'h0, 1'b0, 0, 1'b0);
        finish_rsp(1'b0);
        chk("misw_psel_cycles", 64'(cap_psel), 64'd0);
        chk("misw_err", 64'(cap_err), 64'd1);
        issue(1'b0, 12'h0A4, 32'h0, 2, 32'h0BADC0DE, 1'b0, 0, 1'b0);
        finish_rsp(1'b0);
        chk("rd2_rdata", 64'(cap_rdata), 64'h0BADC0DE);

        // reset during ACCESS
        issue(1'b0, 12'h0C0, 32'h1111_2222, 1000, 32'h3333_4444, 1'b0, 0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("rstacc_psel", 64'(psel), 64'd0);
        chk("rstacc_penable", 64'(penable), 64'd0);
        chk("rstacc_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rstacc_rsp_valid", 64'(rsp_valid), 64'd0);
        t_valid = 1'b0;
        h_addr  = '0;
        h_write = 1'b0;
        h_wdata = '0;
        @(negedge clk);
        #2;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        issue(1'b1, 12'h100, 32'hA5A5_0001, 0, 32'h0, 1'b0, 0, 1'b0);
        finish_rsp(1'b0);
        chk("post_rst_rsp_lat", 64'(first_rsp - t_acc), 64'd2);
        chk("post_rst_err", 64'(cap_err), 64'd0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
